// File: rtl/instruction_execute_muldiv.sv
// EX stage: forwarding muxes, single-cycle ALU, EX/MEM register and a
// multi-cycle multiply/divide unit owning the architectural HI/LO registers.
module instruction_execute_muldiv #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG      = 5,
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = NB_DATA
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_flush,
  input  logic [NB_DATA-1:0] i_RA,
  input  logic [NB_DATA-1:0] i_RB,
  input  logic [NB_DATA-1:0] i_inmediato,
  input  logic [NB_REG-1:0]  i_rt,
  input  logic [NB_REG-1:0]  i_rd,
  input  logic [4:0]         i_shamt,
  input  logic [5:0]         i_op,
  input  logic               i_EX_alu_src,
  input  logic               i_EX_reg_dst,
  input  logic               i_WB_write,
  input  logic               i_WB_mem_to_reg,
  input  logic               i_MEM_read,
  input  logic               i_MEM_write,
  input  logic [1:0]         i_corto_rs,
  input  logic [1:0]         i_corto_rt,
  input  logic [NB_DATA-1:0] i_input_ALU_MEM,
  input  logic [NB_DATA-1:0] i_output_WB,
  output logic               o_stall,
  output logic               o_busy,
  output logic               o_valid,
  output logic               o_WB_write,
  output logic               o_WB_mem_to_reg,
  output logic               o_MEM_read,
  output logic               o_MEM_write,
  output logic [NB_REG-1:0]  o_write_reg,
  output logic [NB_DATA-1:0] o_ALU_result,
  output logic [NB_DATA-1:0] o_data_to_write_in_MEM,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);
  localparam int CNT_MAX = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int NB_CNT  = $clog2(CNT_MAX + 1);

  localparam logic [5:0] OP_SLL  = 6'b000000, OP_SRL  = 6'b000010, OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_MFHI = 6'b010000, OP_MTHI = 6'b010001;
  localparam logic [5:0] OP_MFLO = 6'b010010, OP_MTLO = 6'b010011;
  localparam logic [5:0] OP_MULT = 6'b011000, OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV  = 6'b011010, OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_AND  = 6'b100100, OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110, OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010, OP_SLTU = 6'b101011;

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY} state_t;

  function automatic logic [NB_DATA-1:0] cond_neg(input logic [NB_DATA-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t                   state_q, state_d;
  logic [NB_CNT-1:0]        cnt_q;
  logic signed [NB_DATA-1:0] op_a, op_b_fwd, op_b, alu_res;
  logic [NB_DATA-1:0]       opa_q, opb_q, rem_q, rem_d, quo_d;
  logic [NB_DATA:0]         div_shift, div_trial;
  logic                     div_ge, mul_signed_q, neg_quo_q, neg_rem_q;
  logic [2*NB_DATA-1:0]     mul_ext_a, mul_ext_b, mul_prod;
  logic                     is_mul, is_div, is_mt, is_hilo, no_wb;
  logic                     accept, start_mul, start_div, done, bubble, div_signed;

  always_comb begin
    case (i_corto_rs)
      2'b00:   op_a = i_RA;
      2'b01:   op_a = i_output_WB;
      2'b10:   op_a = i_input_ALU_MEM;
      default: op_a = '0;
    endcase
    case (i_corto_rt)
      2'b00:   op_b_fwd = i_RB;
      2'b01:   op_b_fwd = i_output_WB;
      2'b10:   op_b_fwd = i_input_ALU_MEM;
      default: op_b_fwd = '0;
    endcase
    op_b = i_EX_alu_src ? i_inmediato : op_b_fwd;
  end

  assign is_mul     = (i_op == OP_MULT) || (i_op == OP_MULTU);
  assign is_div     = (i_op == OP_DIV) || (i_op == OP_DIVU);
  assign is_mt      = (i_op == OP_MTHI) || (i_op == OP_MTLO);
  assign is_hilo    = is_mul || is_div || is_mt || (i_op == OP_MFHI) || (i_op == OP_MFLO);
  assign no_wb      = is_mul || is_div || is_mt;
  assign o_busy     = (state_q != IDLE);
  assign o_stall    = i_valid && o_busy && is_hilo;
  assign accept     = i_valid && !o_stall && !i_flush;
  assign start_mul  = accept && is_mul;
  assign start_div  = accept && is_div;
  assign done       = o_busy && (cnt_q == '0);
  assign bubble     = !i_valid || i_flush || o_stall;
  assign div_signed = (i_op == OP_DIV);

  always_comb begin
    alu_res = '0;
    casez (i_op)
      OP_SLL:    alu_res = op_b << i_shamt;
      OP_SRL:    alu_res = op_b >> i_shamt;
      OP_SRA:    alu_res = op_b >>> i_shamt;
      6'b10000?: alu_res = op_a + op_b;
      6'b10001?: alu_res = op_a - op_b;
      OP_AND:    alu_res = op_a & op_b;
      OP_OR:     alu_res = op_a | op_b;
      OP_XOR:    alu_res = op_a ^ op_b;
      OP_NOR:    alu_res = ~(op_a | op_b);
      OP_SLT:    alu_res = NB_DATA'(op_a < op_b);
      OP_SLTU:   alu_res = NB_DATA'($unsigned(op_a) < $unsigned(op_b));
      OP_MFHI:   alu_res = o_hi;
      OP_MFLO:   alu_res = o_lo;
      default:   alu_res = '0;
    endcase
  end

  // Sign extension makes the truncated 2N-bit product correct for MULT too.
  assign mul_ext_a = {{NB_DATA{mul_signed_q & opa_q[NB_DATA-1]}}, opa_q};
  assign mul_ext_b = {{NB_DATA{mul_signed_q & opb_q[NB_DATA-1]}}, opb_q};
  assign mul_prod  = mul_ext_a * mul_ext_b;

  // Restoring step: dividend bits shift out of opa_q's top, quotient bits in at the bottom.
  assign div_shift = {rem_q, opa_q[NB_DATA-1]};
  assign div_trial = div_shift - {1'b0, opb_q};
  assign div_ge    = !div_trial[NB_DATA];
  assign rem_d     = div_ge ? div_trial[NB_DATA-1:0] : div_shift[NB_DATA-1:0];
  assign quo_d     = {opa_q[NB_DATA-2:0], div_ge};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_mul)      state_d = MUL_BUSY;
        else if (start_div) state_d = DIV_BUSY;
      end
      MUL_BUSY, DIV_BUSY: if (cnt_q == '0) state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_mul)                cnt_q <= NB_CNT'(MUL_LATENCY - 1);
      else if (start_div)           cnt_q <= NB_CNT'(DIV_LATENCY - 1);
      else if (o_busy && !done)     cnt_q <= cnt_q - NB_CNT'(1);
    end
  end

  // Divide-by-zero keeps the quotient positive so LO ends as all ones and HI as the dividend.
  always_ff @(posedge i_clk) begin
    if (start_mul) begin
      opa_q        <= op_a;
      opb_q        <= op_b;
      mul_signed_q <= (i_op == OP_MULT);
    end else if (start_div) begin
      opa_q     <= cond_neg(op_a, div_signed && op_a[NB_DATA-1]);
      opb_q     <= cond_neg(op_b, div_signed && op_b[NB_DATA-1]);
      rem_q     <= '0;
      neg_quo_q <= div_signed && (op_a[NB_DATA-1] ^ op_b[NB_DATA-1]) && (op_b != '0);
      neg_rem_q <= div_signed && op_a[NB_DATA-1];
    end else if (state_q == DIV_BUSY) begin
      opa_q <= quo_d;
      rem_q <= rem_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_hi <= '0;
      o_lo <= '0;
    end else if (done && state_q == MUL_BUSY) begin
      {o_hi, o_lo} <= mul_prod;
    end else if (done && state_q == DIV_BUSY) begin
      o_hi <= cond_neg(rem_d, neg_rem_q);
      o_lo <= cond_neg(quo_d, neg_quo_q);
    end else if (accept && i_op == OP_MTHI) begin
      o_hi <= op_a;
    end else if (accept && i_op == OP_MTLO) begin
      o_lo <= op_a;
    end
  end

  // EX/MEM boundary
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid                <= 1'b0;
      o_WB_write             <= 1'b0;
      o_WB_mem_to_reg        <= 1'b0;
      o_MEM_read             <= 1'b0;
      o_MEM_write            <= 1'b0;
      o_write_reg            <= '0;
      o_ALU_result           <= '0;
      o_data_to_write_in_MEM <= '0;
    end else begin
      o_valid                <= !bubble;
      o_WB_write             <= !bubble && !no_wb && i_WB_write;
      o_WB_mem_to_reg        <= !bubble && !no_wb && i_WB_mem_to_reg;
      o_MEM_read             <= !bubble && !no_wb && i_MEM_read;
      o_MEM_write            <= !bubble && !no_wb && i_MEM_write;
      o_write_reg            <= bubble ? '0 : (i_EX_reg_dst ? i_rd : i_rt);
      o_ALU_result           <= bubble ? '0 : alu_res;
      o_data_to_write_in_MEM <= bubble ? '0 : op_b_fwd;
    end
  end
endmodule
